matrix_tile_loader: RTL and testbench

- Upstream feeder for matrix_transpose_top.
- Accepts a serial, row-major stream of DATA_WIDTH elements with valid/ready handshake and assembles it into NUM_MG x NUM_PE tiles.
- Presents each completed tile as a parallel array with in_val.
- Ping-pong (two-bank) buffering: the next tile fills while the current one waits for the transpose stage. Sustained throughput is 1 element/cycle.

---
 rtl/matrix_transpose_pkg.sv | 23 ++
 rtl/matrix_tile_loader_bank.sv | 27 ++
 rtl/matrix_tile_loader.sv | 116 +++++++++++
 tb/tb_matrix_tile_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_transpose_pkg.sv
// Shared types and sizing helpers for the matrix transpose datapath and its feeders.
package matrix_transpose_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_MG     = 32;
  localparam int DEF_NUM_PE     = DEF_NUM_MG;

  // Index width that stays legal for a dimension of 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MG_W = (DEF_NUM_MG > 1) ? $clog2(DEF_NUM_MG) : 1;
  localparam int PE_W = (DEF_NUM_PE > 1) ? $clog2(DEF_NUM_PE) : 1;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  typedef logic [DEF_DATA_WIDTH-1:0] elem_t;

endpackage

// File: rtl/matrix_tile_loader_bank.sv
// One tile-sized storage bank: single-element write port, whole-array read.
module tile_buffer_bank
  import matrix_transpose_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_MG     = DEF_NUM_MG,
  parameter int NUM_PE     = NUM_MG,
  parameter int RW         = idx_w(NUM_MG),
  parameter int CW         = idx_w(NUM_PE)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [RW-1:0]         row_i,
  input  logic [CW-1:0]         col_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] rd_o [0:NUM_MG-1][0:NUM_PE-1]
);

  logic [DATA_WIDTH-1:0] mem_q [0:NUM_MG-1][0:NUM_PE-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[row_i][col_i] <= data_i;
  end

  assign rd_o = mem_q;

endmodule

// File: rtl/matrix_tile_loader.sv
// Row-major stream to NUM_MG x NUM_PE tile assembler with two-bank ping-pong buffering.
module matrix_tile_loader
  import matrix_transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG     = 32,
  parameter int NUM_PE     = NUM_MG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_val,
  output logic                  s_rdy,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] tile_elements [0:NUM_MG-1][0:NUM_PE-1],
  output logic                  in_val,
  input  logic                  in_rdy,
  output logic                  err_last
);

  localparam int RW = idx_w(NUM_MG);
  localparam int CW = idx_w(NUM_PE);

  bank_state_e   state_q [2];
  bank_state_e   state_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          err_q, err_d;

  logic          acc, tacc, col_end, final_elem;
  logic [1:0]    we;
  logic [DATA_WIDTH-1:0] rd0 [0:NUM_MG-1][0:NUM_PE-1];
  logic [DATA_WIDTH-1:0] rd1 [0:NUM_MG-1][0:NUM_PE-1];

  // Handshakes look only at registered state, so s_val never reaches s_rdy.
  always_comb begin
    s_rdy      = !rst && (state_q[wr_bank_q] == BANK_EMPTY);
    in_val     = !rst && (state_q[rd_bank_q] == BANK_FULL);
    acc        = s_val && s_rdy;
    tacc       = in_val && in_rdy;
    col_end    = (col_q == CW'(NUM_PE-1));
    final_elem = col_end && (row_q == RW'(NUM_MG-1));
    we         = {acc && wr_bank_q, acc && !wr_bank_q};
  end

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    row_d     = row_q;
    col_d     = col_q;
    err_d     = err_q;
    if (acc) begin
      // s_last is only audited; framing always follows the element count.
      if (s_last != final_elem) err_d = 1'b1;
      if (final_elem) begin
        row_d                = '0;
        col_d                = '0;
        state_d[wr_bank_q]   = BANK_FULL;
        wr_bank_d            = !wr_bank_q;
      end else if (col_end) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    // acc needs the write bank EMPTY and tacc the read bank FULL, so they never collide.
    if (tacc) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = !rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      err_q      <= err_d;
    end
  end

  assign err_last = err_q;

  tile_buffer_bank #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_MG(NUM_MG), .NUM_PE(NUM_PE), .RW(RW), .CW(CW)
  ) u_bank0 (
    .clk(clk), .we_i(we[0]), .row_i(row_q), .col_i(col_q), .data_i(s_data), .rd_o(rd0)
  );

  tile_buffer_bank #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_MG(NUM_MG), .NUM_PE(NUM_PE), .RW(RW), .CW(CW)
  ) u_bank1 (
    .clk(clk), .we_i(we[1]), .row_i(row_q), .col_i(col_q), .data_i(s_data), .rd_o(rd1)
  );

  always_comb begin
    for (int i = 0; i < NUM_MG; i++)
      for (int j = 0; j < NUM_PE; j++)
        tile_elements[i][j] = rd_bank_q ? rd1[i][j] : rd0[i][j];
  end

endmodule

// File: tb/tb_matrix_tile_loader.sv
// Directed + randomized bench for matrix_tile_loader against a tile-queue reference model.
module tb_matrix_tile_loader;

  localparam int DW = 16;
  localparam int MG = 4;
  localparam int PE = 4;
  localparam int NE = MG * PE;
  localparam int TW = DW * NE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_val = 1'b0;
  logic          s_last = 1'b0;
  logic          in_rdy = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_rdy, in_val, err_last;
  logic [DW-1:0] tile [0:MG-1][0:PE-1];

  always #5 clk = ~clk;

  matrix_tile_loader #(.DATA_WIDTH(DW), .NUM_MG(MG), .NUM_PE(PE)) dut (
    .clk(clk), .rst(rst), .s_val(s_val), .s_rdy(s_rdy), .s_data(s_data), .s_last(s_last),
    .tile_elements(tile), .in_val(in_val), .in_rdy(in_rdy), .err_last(err_last)
  );

  int            n_cmp = 0;
  int            n_mis = 0;
  int            dut_acc = 0;
  logic          last_acc = 1'b0;
  // Reference: completed tiles waiting in arrival order, plus the tile being filled.
  logic [TW-1:0] tq[$];
  logic [DW-1:0] cur[$];
  logic          err_m = 1'b0;

  function automatic logic [TW-1:0] flat();
    logic [TW-1:0] r;
    r = '0;
    for (int i = 0; i < MG; i++)
      for (int j = 0; j < PE; j++)
        r[(i*PE+j)*DW +: DW] = tile[i][j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic step();
    logic          exp_rdy, exp_val;
    logic [TW-1:0] t;
    @(negedge clk);
    exp_rdy = !rst && (tq.size() < 2);
    exp_val = !rst && (tq.size() > 0);
    chk("s_rdy", TW'(s_rdy), TW'(exp_rdy));
    chk("in_val", TW'(in_val), TW'(exp_val));
    chk("err_last", TW'(err_last), TW'(err_m));
    if (exp_val) chk("tile", flat(), tq[0]);
    last_acc = s_val && s_rdy;
    if (last_acc) dut_acc++;
    if (rst) begin
      tq.delete();
      cur.delete();
      err_m = 1'b0;
    end else begin
      if (in_rdy && exp_val) void'(tq.pop_front());
      if (s_val && exp_rdy) begin
        if (s_last != (cur.size() == NE-1)) err_m = 1'b1;
        cur.push_back(s_data);
        if (cur.size() == NE) begin
          t = '0;
          for (int k = 0; k < NE; k++) t[k*DW +: DW] = cur[k];
          tq.push_back(t);
          cur.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    s_val  = 1'b1;
    s_data = d;
    s_last = l;
    for (int n = 0; n < 50; n++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", TW'(last_acc), TW'(1));
    s_val = 1'b0;
  endtask

  task automatic do_reset();
    s_val = 1'b0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
  endtask

  initial begin
    int base, idx, total, cyc;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    chk("rst_err", TW'(err_last), TW'(0));

    // Back-to-back single tile with consumer always ready.
    in_rdy = 1'b1;
    for (int k = 0; k < NE; k++) send(DW'(k), k == NE-1);
    chk("t1_inval", TW'(in_val), TW'(1));
    chk("t1_corner", TW'(tile[3][3]), TW'(15));
    chk("t1_mid", TW'(tile[2][1]), TW'(9));
    step();
    chk("t1_freed", TW'(in_val), TW'(0));
    step();

    // Stall with consumer blocked: two tiles land, element 32 is held.
    do_reset();
    base = dut_acc;
    idx  = 0;
    for (int c = 0; c < 90 && idx <= 40; c++) begin
      in_rdy = (c >= 45);
      s_val  = 1'b1;
      s_data = DW'(idx);
      s_last = (idx % NE) == NE-1;
      step();
      idx = dut_acc - base;
      if (c == 44) begin
        chk("stall_count", TW'(idx), TW'(32));
        chk("stall_rdy", TW'(s_rdy), TW'(0));
      end
    end
    chk("burst_done", TW'(idx), TW'(41));
    s_val = 1'b0;
    repeat (4) step();

    // Mis-placed s_last on element 7.
    do_reset();
    in_rdy = 1'b0;
    for (int k = 0; k < NE; k++) begin
      send(DW'(200 + k), k == 7);
      if (k == 7) chk("err_set", TW'(err_last), TW'(1));
    end
    chk("err_sticky", TW'(err_last), TW'(1));
    chk("err_tile", TW'(tile[1][3]), TW'(207));
    in_rdy = 1'b1;
    repeat (2) step();
    chk("err_hold", TW'(err_last), TW'(1));

    // Final write of tile 1 coincides with accept of tile 0.
    do_reset();
    in_rdy = 1'b0;
    for (int k = 0; k < 2*NE; k++) begin
      in_rdy = (k == 2*NE-1);
      send(DW'(300 + k), (k % NE) == NE-1);
    end
    chk("pp_inval", TW'(in_val), TW'(1));
    chk("pp_tile1", TW'(tile[0][0]), TW'(316));
    chk("pp_rdy", TW'(s_rdy), TW'(1));
    in_rdy = 1'b0;
    step();
    chk("pp_stable", TW'(tile[3][3]), TW'(331));
    in_rdy = 1'b1;
    repeat (2) step();

    // Reset mid-tile discards the partial tile.
    do_reset();
    for (int k = 0; k < 5; k++) send(DW'(50 + k), 1'b0);
    do_reset();
    for (int k = 0; k < NE; k++) send(DW'(100 + k), k == NE-1);
    chk("rr_first", TW'(tile[0][0]), TW'(100));
    chk("rr_last", TW'(tile[3][3]), TW'(115));
    chk("rr_err", TW'(err_last), TW'(0));
    repeat (3) step();

    // Random bubbles and consumer back-pressure over ten tiles.
    do_reset();
    total = 0;
    cyc   = 0;
    last_acc = 1'b1;
    s_val = 1'b0;
    while (total < 10*NE && cyc < 3000) begin
      if (!s_val || last_acc) begin
        s_val  = ($urandom_range(0, 3) != 0);
        s_data = DW'($urandom);
        s_last = (total % NE) == NE-1;
      end
      in_rdy = $urandom_range(0, 1) == 1;
      step();
      if (last_acc) total++;
      cyc++;
    end
    chk("rand_count", TW'(total), TW'(10*NE));
    s_val  = 1'b0;
    in_rdy = 1'b1;
    repeat (4) step();
    chk("rand_drained", TW'(in_val), TW'(0));
    chk("rand_err", TW'(err_last), TW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
